// File: rtl/glitch_sequencer.sv
// -----------------------------------------------------------------------------
// glitch_sequencer
//
// Runs the glitch program held in an external ROM, one 12-bit instruction at a
// time. Instruction word layout: {op[11:10], bus[9], data[8:1], ack[0]}.
//   op 10 DELAY   : wait delay_len(data) + 1 cycles (delay table lookup)
//   op 01 DAC_UP  : write data to the DAC on the selected bus via req/ack
//   op 00 I2C_CHK : wait for a snooped byte on bus, compare byte and ACK bit
//   op 11         : illegal, faults
// Every instruction costs FETCH + EXEC plus the duration of its operation.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start, abort        host run request / stop request (abort has priority)
//   instr_pt, instr     ROM index out, ROM word back (combinational)
//   delay_num,delay_len delay table index out, length back (combinational)
//   dac_data, dac_bus,
//   dac_req, dac_ack    DAC writer handshake (ack is a single-cycle pulse)
//   i2c_valid, i2c_bus,
//   i2c_byte, i2c_ack   I2C snooper byte stream
//   busy, done, fault,
//   fault_pt            host status; done/fault are sticky until next start
// -----------------------------------------------------------------------------
module glitch_sequencer #(
  parameter int unsigned PROG_LEN    = 17,
  parameter logic [31:0] CHK_TIMEOUT = 32'd100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [7:0]  instr_pt,
  input  logic [11:0] instr,
  output logic [7:0]  delay_num,
  input  logic [31:0] delay_len,
  output logic [7:0]  dac_data,
  output logic        dac_bus,
  output logic        dac_req,
  input  logic        dac_ack,
  input  logic        i2c_valid,
  input  logic        i2c_bus,
  input  logic [7:0]  i2c_byte,
  input  logic        i2c_ack,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [7:0]  fault_pt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_DLY   = 3'd3;
  localparam logic [2:0] S_DAC   = 3'd4;
  localparam logic [2:0] S_CHK   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_FAULT = 3'd7;

  localparam logic [1:0] OP_CHK = 2'b00;
  localparam logic [1:0] OP_DAC = 2'b01;
  localparam logic [1:0] OP_DLY = 2'b10;

  localparam logic [7:0]  LAST_PT  = 8'(PROG_LEN - 1);
  localparam logic [31:0] TMO_LAST = CHK_TIMEOUT - 32'd1;

  logic [2:0]  state_q,    state_d;
  logic [7:0]  instr_pt_q, instr_pt_d;
  logic [7:0]  delay_num_q, delay_num_d;
  logic [11:0] ir_q,       ir_d;
  logic [31:0] cnt_q,      cnt_d;
  logic [31:0] tmo_q,      tmo_d;
  logic [7:0]  dac_data_q, dac_data_d;
  logic        dac_bus_q,  dac_bus_d;
  logic        dac_req_q,  dac_req_d;
  logic        done_q,     done_d;
  logic        fault_q,    fault_d;
  logic [7:0]  fault_pt_q, fault_pt_d;

  logic adv;        // current instruction finished successfully
  logic flt;        // current instruction failed
  logic byte_hit;   // snooped byte is on the bus this check watches
  logic byte_ok;    // snooped byte and ACK bit match the expectation

  assign byte_hit = i2c_valid && (i2c_bus == ir_q[9]);
  assign byte_ok  = (i2c_byte == ir_q[8:1]) && (i2c_ack == ir_q[0]);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statements can leave one unassigned and infer a latch.
    state_d     = state_q;
    instr_pt_d  = instr_pt_q;
    delay_num_d = delay_num_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    dac_data_d  = dac_data_q;
    dac_bus_d   = dac_bus_q;
    dac_req_d   = dac_req_q;
    done_d      = done_q;
    fault_d     = fault_q;
    fault_pt_d  = fault_pt_q;
    adv         = 1'b0;
    flt         = 1'b0;

    if (abort) begin
      // Abort overrides any in-flight update; only the state and the DAC
      // request change, status and instr_pt stay where they were.
      state_d   = S_IDLE;
      dac_req_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAULT: begin
          if (start) begin
            instr_pt_d = 8'd0;
            done_d     = 1'b0;
            fault_d    = 1'b0;
            fault_pt_d = 8'd0;
            state_d    = S_FETCH;
          end
        end
        S_FETCH: begin
          ir_d        = instr;
          delay_num_d = instr[8:1];
          state_d     = S_EXEC;
        end
        S_EXEC: begin
          case (ir_q[11:10])
            OP_DLY: begin
              cnt_d   = delay_len;
              state_d = S_DLY;
            end
            OP_DAC: begin
              dac_data_d = ir_q[8:1];
              dac_bus_d  = ir_q[9];
              dac_req_d  = 1'b1;
              state_d    = S_DAC;
            end
            OP_CHK: begin
              tmo_d   = 32'd0;
              state_d = S_CHK;
            end
            default: flt = 1'b1;
          endcase
        end
        S_DLY: begin
          // Counting down to and including zero gives delay_len+1 cycles.
          if (cnt_q == 32'd0) adv = 1'b1;
          else                cnt_d = cnt_q - 32'd1;
        end
        S_DAC: begin
          if (dac_ack) begin
            dac_req_d = 1'b0;
            adv       = 1'b1;
          end
        end
        S_CHK: begin
          // A qualifying byte is judged before the timeout, so a byte that
          // lands on the final allowed cycle still gets compared.
          if (byte_hit) begin
            if (byte_ok) adv = 1'b1;
            else         flt = 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            flt = 1'b1;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (adv) begin
        if (instr_pt_q == LAST_PT) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          instr_pt_d = instr_pt_q + 8'd1;
          state_d    = S_FETCH;
        end
      end

      if (flt) begin
        fault_d    = 1'b1;
        fault_pt_d = instr_pt_q;
        state_d    = S_FAULT;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      instr_pt_q  <= 8'd0;
      delay_num_q <= 8'd0;
      ir_q        <= 12'd0;
      cnt_q       <= 32'd0;
      tmo_q       <= 32'd0;
      dac_data_q  <= 8'd0;
      dac_bus_q   <= 1'b0;
      dac_req_q   <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      fault_pt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      instr_pt_q  <= instr_pt_d;
      delay_num_q <= delay_num_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      dac_data_q  <= dac_data_d;
      dac_bus_q   <= dac_bus_d;
      dac_req_q   <= dac_req_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      fault_pt_q  <= fault_pt_d;
    end
  end

  assign busy = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_DLY) ||
                (state_q == S_DAC)   || (state_q == S_CHK);

  assign instr_pt  = instr_pt_q;
  assign delay_num = delay_num_q;
  assign dac_data  = dac_data_q;
  assign dac_bus   = dac_bus_q;
  assign dac_req   = dac_req_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign fault_pt  = fault_pt_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_glitch_sequencer
//
// Drives glitch_sequencer from a behavioural ROM / delay table and a DAC
// responder. Expected timing and status come from the instruction rules:
// DELAY costs 3+len cycles, DAC_UP costs 2+ack latency, a check costs 2 plus
// the cycles until a matching byte, and faults report the failing index.
// -----------------------------------------------------------------------------
module tb_glitch_sequencer;

  localparam int unsigned PL  = 4;
  localparam logic [31:0] TMO = 32'd10;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  instr_pt, delay_num, dac_data, fault_pt;
  logic [11:0] instr;
  logic [31:0] delay_len;
  logic        dac_bus, dac_req, dac_ack;
  logic        i2c_valid, i2c_bus, i2c_ack;
  logic [7:0]  i2c_byte;
  logic        busy, done, fault;

  logic [11:0] rom     [256];
  logic [31:0] dtab    [256];
  int unsigned lat_tbl [256];
  bit          spur_en;
  int unsigned req_age;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign instr     = rom[instr_pt];
  assign delay_len = dtab[delay_num];

  glitch_sequencer #(.PROG_LEN(PL), .CHK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .instr_pt(instr_pt), .instr(instr),
    .delay_num(delay_num), .delay_len(delay_len),
    .dac_data(dac_data), .dac_bus(dac_bus), .dac_req(dac_req), .dac_ack(dac_ack),
    .i2c_valid(i2c_valid), .i2c_bus(i2c_bus), .i2c_byte(i2c_byte), .i2c_ack(i2c_ack),
    .busy(busy), .done(done), .fault(fault), .fault_pt(fault_pt)
  );

  // DAC writer model: acks on the lat_tbl-th cycle the request is seen high,
  // optionally throws stray acks while no request is pending.
  initial begin
    dac_ack = 1'b0;
    req_age = 0;
    forever begin
      @(posedge clk); #1;
      if (dac_req === 1'b1) begin
        req_age++;
        dac_ack = (req_age == lat_tbl[instr_pt]);
      end else begin
        req_age = 0;
        dac_ack = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got hang want completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] mk(input logic [1:0] op, input logic bus,
                                     input logic [7:0] data, input logic ack);
    return {op, bus, data, ack};
  endfunction

  // Expected busy-cycle count for a run of the loaded program (no checks).
  function automatic int model_busy();
    int t = 0;
    for (int i = 0; i < int'(PL); i++) begin
      if (rom[i][11:10] == 2'b10)      t += 3 + int'(dtab[rom[i][8:1]]);
      else if (rom[i][11:10] == 2'b01) t += 2 + int'(lat_tbl[i]);
    end
    return t;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic go_idle();
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  // Runs the loaded program and counts cycles with busy high.
  task automatic run_busy(input bit poke, output int cyc);
    pulse_start();
    cyc = 0;
    while (busy === 1'b1 && cyc < 5000) begin
      cyc++;
      start = (poke && $urandom_range(0, 3) == 0);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; spur_en = 1'b0;
    i2c_valid = 1'b0; i2c_bus = 1'b0; i2c_byte = 8'd0; i2c_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({busy, done, fault, dac_req} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got busy/done/fault/req=%b want 0000", {busy, done, fault, dac_req});
    end
    n_cmp++;
    if ({instr_pt, delay_num, fault_pt} !== 24'd0) begin
      n_bad++; $display("FAIL reset_idx: got pt=%0h dn=%0h fpt=%0h want 0", instr_pt, delay_num, fault_pt);
    end
    n_cmp++;
    if ({dac_data, dac_bus} !== 9'd0) begin
      n_bad++; $display("FAIL reset_dac: got data=%0h bus=%0b want 0", dac_data, dac_bus);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    rom[0] = mk(2'b01, 1'b1, 8'h5A, 1'b0);
    lat_tbl[0] = 200;
    pulse_start();
    while (dac_req !== 1'b1 && w < 10) begin w++; tick(); end
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++;
    if ({dac_req, busy} !== 2'b00) begin
      n_bad++; $display("FAIL reset_mid_req: got req/busy=%b want 00", {dac_req, busy});
    end
    n_cmp++;
    if ({instr_pt, dac_data} !== 16'd0) begin
      n_bad++; $display("FAIL reset_mid_regs: got pt=%0h data=%0h want 0", instr_pt, dac_data);
    end
    lat_tbl[0] = 1;
  endtask

  task automatic test_delay();
    int cyc;
    rom[0] = mk(2'b10, 1'b0, 8'd3, 1'b0);
    dtab[3] = 32'h1B;
    for (int i = 1; i < int'(PL); i++) begin
      logic [7:0] idx;
      idx = 8'($urandom_range(4, 255));
      rom[i] = mk(2'b10, 1'($urandom), idx, 1'($urandom));
      dtab[idx] = (i == 1) ? 32'd0 : 32'($urandom_range(0, 20));
    end
    run_busy(1'b0, cyc);
    n_cmp++;
    if (cyc != model_busy()) begin
      n_bad++; $display("FAIL delay_cycles: got %0d want %0d", cyc, model_busy());
    end
    n_cmp++;
    if ({done, busy, fault} !== 3'b100) begin
      n_bad++; $display("FAIL delay_status: got done/busy/fault=%b want 100", {done, busy, fault});
    end
    n_cmp++;
    if (instr_pt !== 8'(PL - 1) || delay_num !== rom[PL-1][8:1]) begin
      n_bad++; $display("FAIL delay_idx: got pt=%0h dn=%0h want %0h %0h", instr_pt, delay_num, PL - 1, rom[PL-1][8:1]);
    end
  endtask

  task automatic test_dac();
    logic [7:0] exp_pt;
    spur_en = 1'b1;
    for (int i = 0; i < int'(PL); i++) begin
      rom[i] = mk(2'b01, 1'($urandom), 8'($urandom), 1'($urandom));
      lat_tbl[i] = $urandom_range(1, 6);
    end
    rom[0] = mk(2'b01, 1'b1, 8'h8E, 1'b0);
    lat_tbl[0] = 5;
    pulse_start();
    for (int i = 0; i < int'(PL); i++) begin
      int w = 0, hi = 0, bad = 0;
      while (dac_req !== 1'b1 && w < 10) begin w++; tick(); end
      while (dac_req === 1'b1 && hi < 50) begin
        hi++;
        if (dac_data !== rom[i][8:1] || dac_bus !== rom[i][9]) bad++;
        tick();
      end
      n_cmp++;
      if (w != 2 || hi != int'(lat_tbl[i])) begin
        n_bad++; $display("FAIL dac_req_len[%0d]: got wait=%0d high=%0d want 2 %0d", i, w, hi, lat_tbl[i]);
      end
      n_cmp++;
      if (bad != 0) begin
        n_bad++; $display("FAIL dac_stable[%0d]: got %0d bad cycles want 0", i, bad);
      end
      exp_pt = (i == int'(PL) - 1) ? 8'(PL - 1) : 8'(i + 1);
      n_cmp++;
      if (instr_pt !== exp_pt) begin
        n_bad++; $display("FAIL dac_next_pt[%0d]: got %0h want %0h", i, instr_pt, exp_pt);
      end
    end
    tick(); tick();
    n_cmp++;
    if (done !== 1'b1 || dac_data !== rom[PL-1][8:1] || dac_bus !== rom[PL-1][9]) begin
      n_bad++; $display("FAIL dac_hold: got done=%0b data=%0h bus=%0b want 1 %0h %0b",
                        done, dac_data, dac_bus, rom[PL-1][8:1], rom[PL-1][9]);
    end
    spur_en = 1'b0;
  endtask

  task automatic test_chk_pass();
    logic [7:0] exp_pt;
    for (int i = 0; i < int'(PL); i++) rom[i] = mk(2'b00, 1'($urandom), 8'($urandom), 1'($urandom));
    rom[1] = mk(2'b00, 1'b1, 8'h84, 1'b0);
    pulse_start();
    for (int i = 0; i < int'(PL); i++) begin
      int n;
      n = (i == 0) ? 9 : $urandom_range(0, 8);
      if (i == 1) n = 1;
      tick(); tick();
      for (int k = 0; k < n; k++) begin
        i2c_valid = (i == 1) ? 1'b1 : 1'($urandom);
        i2c_bus   = ~rom[i][9];
        i2c_byte  = (i == 1) ? 8'h84 : 8'($urandom);
        i2c_ack   = (i == 1) ? 1'b0 : 1'($urandom);
        tick();
      end
      i2c_valid = 1'b1; i2c_bus = rom[i][9]; i2c_byte = rom[i][8:1]; i2c_ack = rom[i][0];
      tick();
      i2c_valid = 1'b0;
      exp_pt = (i == int'(PL) - 1) ? 8'(PL - 1) : 8'(i + 1);
      n_cmp++;
      if (fault !== 1'b0 || instr_pt !== exp_pt) begin
        n_bad++; $display("FAIL chk_pass[%0d]: got fault=%0b pt=%0h want 0 %0h", i, fault, instr_pt, exp_pt);
      end
    end
    n_cmp++;
    if ({done, busy} !== 2'b10) begin
      n_bad++; $display("FAIL chk_done: got done/busy=%b want 10", {done, busy});
    end
  endtask

  task automatic test_chk_fail(input bit plan_case);
    int p, s;
    logic [7:0] bad_byte;
    logic       bad_ack;
    p = plan_case ? 1 : $urandom_range(0, 2);
    s = 0;
    for (int i = 0; i < p; i++) begin
      rom[i] = mk(2'b10, 1'b0, 8'(10 + i), 1'b0);
      dtab[10 + i] = 32'($urandom_range(0, 5));
      s += 3 + int'(dtab[10 + i]);
    end
    rom[p] = plan_case ? mk(2'b00, 1'b1, 8'h84, 1'b0) : mk(2'b00, 1'($urandom), 8'($urandom), 1'($urandom));
    bad_byte = rom[p][8:1];
    bad_ack  = rom[p][0];
    if (plan_case)                   bad_byte = 8'h85;
    else if ($urandom_range(0, 1))   bad_byte = bad_byte ^ 8'($urandom_range(1, 255));
    else                             bad_ack  = ~bad_ack;
    pulse_start();
    for (int k = 0; k < s + 2; k++) tick();
    i2c_valid = 1'b1; i2c_bus = rom[p][9]; i2c_byte = bad_byte; i2c_ack = bad_ack;
    tick();
    i2c_valid = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({fault, busy, done} !== 3'b100 || fault_pt !== 8'(p)) begin
      n_bad++; $display("FAIL chk_fail: got fault/busy/done=%b fpt=%0h want 100 %0h", {fault, busy, done}, fault_pt, p);
    end
    pulse_start();
    n_cmp++;
    if ({fault, busy} !== 2'b01 || instr_pt !== 8'd0 || fault_pt !== 8'd0) begin
      n_bad++; $display("FAIL chk_restart: got fault/busy=%b pt=%0h fpt=%0h want 01 0 0", {fault, busy}, instr_pt, fault_pt);
    end
    go_idle();
  endtask

  task automatic test_timeout();
    int t = 0;
    rom[0] = mk(2'b00, 1'($urandom), 8'($urandom), 1'($urandom));
    pulse_start();
    tick(); tick();
    while (fault !== 1'b1 && t < 100) begin
      i2c_valid = 1'($urandom); i2c_bus = ~rom[0][9]; i2c_byte = rom[0][8:1]; i2c_ack = rom[0][0];
      tick();
      t++;
    end
    i2c_valid = 1'b0;
    n_cmp++;
    if (t != int'(TMO) || fault_pt !== 8'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL chk_timeout: got %0d cycles fpt=%0h busy=%0b want %0d 0 0", t, fault_pt, busy, TMO);
    end
    go_idle();
  endtask

  task automatic test_illegal();
    int p, s, t;
    p = $urandom_range(0, 2);
    s = 0;
    t = 0;
    for (int i = 0; i < p; i++) begin
      rom[i] = mk(2'b10, 1'b0, 8'(20 + i), 1'b0);
      dtab[20 + i] = 32'($urandom_range(0, 5));
      s += 3 + int'(dtab[20 + i]);
    end
    rom[p] = {2'b11, 10'($urandom)};
    pulse_start();
    while (fault !== 1'b1 && t < 100) begin tick(); t++; end
    n_cmp++;
    if (t != s + 2 || fault_pt !== 8'(p)) begin
      n_bad++; $display("FAIL illegal_op: got %0d cycles fpt=%0h want %0d %0h", t, fault_pt, s + 2, p);
    end
    go_idle();
  endtask

  task automatic test_abort();
    int w = 0, hi = 0, cyc;
    rom[0] = mk(2'b10, 1'b0, 8'd7, 1'b0);
    dtab[7] = 32'h3B9ACA00;
    pulse_start();
    for (int k = 0; k < int'($urandom_range(3, 40)); k++) tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL abort_pre_busy: got %0b want 1", busy);
    end
    go_idle();
    n_cmp++;
    if ({busy, done, fault} !== 3'b000 || instr_pt !== 8'd0) begin
      n_bad++; $display("FAIL abort_dly: got busy/done/fault=%b pt=%0h want 000 0", {busy, done, fault}, instr_pt);
    end
    // Abort in the same cycle the DAC ack arrives.
    rom[0] = mk(2'b01, 1'b0, 8'h33, 1'b1);
    lat_tbl[0] = 3;
    pulse_start();
    while (dac_req !== 1'b1 && w < 10) begin w++; tick(); end
    while (dac_req === 1'b1 && hi < 3) begin
      hi++;
      if (hi == 3) abort = 1'b1;
      tick();
    end
    abort = 1'b0;
    n_cmp++;
    if ({dac_req, busy, done} !== 3'b000 || instr_pt !== 8'd0) begin
      n_bad++; $display("FAIL abort_ack: got req/busy/done=%b pt=%0h want 000 0", {dac_req, busy, done}, instr_pt);
    end
    // Abort from DONE leaves the sticky done flag alone.
    for (int i = 0; i < int'(PL); i++) rom[i] = mk(2'b10, 1'b0, 8'd0, 1'b0);
    dtab[0] = 32'd0;
    run_busy(1'b0, cyc);
    go_idle();
    tick();
    n_cmp++;
    if ({done, busy} !== 2'b10 || instr_pt !== 8'(PL - 1)) begin
      n_bad++; $display("FAIL abort_done: got done/busy=%b pt=%0h want 10 %0h", {done, busy}, instr_pt, PL - 1);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    spur_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(PL); i++) begin
        logic [7:0] idx;
        idx = 8'($urandom_range(30, 40));
        if ($urandom_range(0, 1)) begin
          rom[i] = mk(2'b10, 1'($urandom), idx, 1'($urandom));
          dtab[idx] = 32'($urandom_range(0, 12));
        end else begin
          rom[i] = mk(2'b01, 1'($urandom), 8'($urandom), 1'($urandom));
          lat_tbl[i] = $urandom_range(1, 4);
        end
      end
      run_busy(1'b1, cyc);
      n_cmp++;
      if (cyc != model_busy() || done !== 1'b1 || fault !== 1'b0) begin
        n_bad++; $display("FAIL b2b_run[%0d]: got %0d cycles done=%0b fault=%0b want %0d 1 0",
                          r, cyc, done, fault, model_busy());
      end
    end
    spur_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; spur_en = 1'b0;
    i2c_valid = 1'b0; i2c_bus = 1'b0; i2c_byte = 8'd0; i2c_ack = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom[i] = 12'd0; dtab[i] = 32'd0; lat_tbl[i] = 1;
    end
    test_reset();
    test_reset_mid();
    test_delay();
    test_dac();
    test_chk_pass();
    test_chk_fail(1'b1);
    test_chk_fail(1'b0);
    test_timeout();
    test_illegal();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/glitch_sequencer.md
Name: glitch_sequencer

Overview:
Executes the glitch program stored in program_rom, one instruction at a time. It drives the ROM's instr_pt and delay_num indices and decodes each 12-bit word {op[11:10], bus[9], data[8:1], ack[0]}. It runs DELAY countdowns, issues DAC level updates through a req/ack handshake, and checks bytes seen by the I2C snooper against expected values. It sits between the ROM/delay table and the DAC writer and I2C monitor, and reports busy, done and fault to the host.

Parameters:
PROG_LEN, 17, number of valid instructions; the last index executed is PROG_LEN-1.
CHK_TIMEOUT, 32'd100000000, maximum cycles an I2C_CHK waits for a byte on its bus before faulting.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle run request
abort  in  1  stop the program, return to IDLE
instr_pt  out  8  ROM instruction index
instr  in  12  ROM word; combinational from instr_pt
delay_num  out  8  delay table index
delay_len  in  32  delay length in clk cycles; combinational from delay_num
dac_data  out  8  DAC code
dac_bus  out  1  bus select for the DAC write (1 = private bus)
dac_req  out  1  DAC write request
dac_ack  in  1  single-cycle DAC write completion
i2c_valid  in  1  snooped byte strobe
i2c_bus  in  1  bus the snooped byte came from
i2c_byte  in  8  snooped byte
i2c_ack  in  1  ACK/NAK bit following the byte (0 = ACK)
busy  out  1  program executing
done  out  1  sticky: program completed
fault  out  1  sticky: check mismatch, timeout or illegal opcode
fault_pt  out  8  instr_pt at the time of the fault

Behaviour:
- Reset: state=IDLE. All outputs 0, internal counters 0.
- States: IDLE, FETCH, EXEC, DLY, DAC, CHK, DONE, FAULT. busy=1 exactly in FETCH, EXEC, DLY, DAC and CHK.
- IDLE/DONE/FAULT + start: instr_pt<=0, done<=0, fault<=0, fault_pt<=0, go to FETCH. start while busy is ignored.
- FETCH (1 cycle): ir<=instr; delay_num<=instr[8:1]; go to EXEC.
- EXEC (1 cycle), decode ir[11:10]:
  - 10 DELAY: cnt<=delay_len, go to DLY.
  - 01 DAC_UP: dac_data<=ir[8:1], dac_bus<=ir[9], dac_req<=1, go to DAC.
  - 00 I2C_CHK: tmo<=0, go to CHK.
  - 11: fault<=1, fault_pt<=instr_pt, go to FAULT.
- DLY: if cnt==0, advance; else cnt<=cnt-1. DLY occupies delay_len+1 cycles. delay_len=0 gives 1 cycle.
- DAC: dac_req held high with dac_data/dac_bus stable. On a cycle with dac_ack=1: dac_req<=0 and advance. dac_ack outside DAC is ignored. dac_data and dac_bus keep their last value after the write.
- CHK:
  - i2c_valid with i2c_bus!=ir[9] is ignored.
  - i2c_valid with i2c_bus==ir[9]: if i2c_byte==ir[8:1] and i2c_ack==ir[0], advance. Otherwise fault<=1, fault_pt<=instr_pt, go to FAULT.
  - With no qualifying byte, tmo increments each cycle. When tmo==CHK_TIMEOUT-1, FAULT with the same updates.
  - A valid byte in the same cycle as the timeout wins (it is compared).
- Advance: if instr_pt==PROG_LEN-1, done<=1 and go to DONE (instr_pt held). Otherwise instr_pt<=instr_pt+1 and go to FETCH. instr_pt is 8 bits and never wraps because PROG_LEN≤256.
- Per-instruction overhead: 2 cycles (FETCH, EXEC) plus the op duration.
- abort (any state, priority over everything except rst): go to IDLE next cycle, dac_req<=0, done/fault unchanged, instr_pt held. An abort in the same cycle as dac_ack also goes to IDLE.
- rst mid-operation: immediate return to reset values on the next edge. dac_req drops even if the handshake is outstanding.

Test Plan:
- Program [DELAY idx3], delay_len(3)=0x1B, PROG_LEN=1, pulse start -> busy high 30 cycles (FETCH, EXEC, 28 DLY), then done=1, busy=0, instr_pt=0.
- DAC_UP data 0x8E bus 1, dac_ack returned 5 cycles after req rises -> dac_req high exactly 5 cycles with dac_data=0x8E and dac_bus=1; req low the cycle after ack; next FETCH has instr_pt=1.
- I2C_CHK expect 0x84 ACK on private bus; inject 0x84 on main bus, then 0x84 with ack=0 on private bus -> first byte ignored, second advances; no fault.
- Same check, inject 0x85 on private bus -> fault=1, fault_pt=index of the check, state FAULT. A following start clears fault and restarts at instr_pt=0.
- CHK_TIMEOUT=10 with no i2c_valid -> fault asserts 10 cycles after entering CHK. Illegal word 12'b11_x -> fault at EXEC.
- abort during DLY with cnt=0x3B9ACA00 -> IDLE next cycle, busy=0. start asserted while busy -> no effect on instr_pt or timing.
